// File: rtl/pool_stream_pkg.sv
// Shared constants and state type for the 2x2 row-pair pooling engine.
package pool_pkg;

   localparam logic POOL_MAX = 1'b0;
   localparam logic POOL_AVG = 1'b1;

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } pool_state_e;

endpackage

// File: rtl/pool_stream_if.sv
// Row-in / pooled-row-out stream bundle for pool_stream.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
// the source holds data/last stable while valid && !ready and never drops valid before transfer.
interface pool_stream_if #(
   parameter int ByteWidth = 22,
   parameter int DataWidth = 8
);
   localparam int InW  = ByteWidth * DataWidth;
   localparam int OutW = (ByteWidth / 2) * DataWidth;

   logic            mode;
   logic            in_valid;
   logic            in_ready;
   logic [InW-1:0]  in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [OutW-1:0] out_data;
   logic            out_last;
   logic            err_odd_frame;

   modport slave (
      input  mode, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, err_odd_frame
   );

   modport master (
      output mode, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, err_odd_frame
   );
endinterface

// File: rtl/pool_reduce4.sv
// Combinational max / rounded average of one 2x2 window.
module pool_reduce4
   import pool_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Signed    = 0
) (
   input  logic [DataWidth-1:0] a,
   input  logic [DataWidth-1:0] b,
   input  logic [DataWidth-1:0] c,
   input  logic [DataWidth-1:0] d,
   input  logic                 mode,
   output logic [DataWidth-1:0] result
);
   localparam int SumW = DataWidth + 2;
   localparam logic [SumW-1:0] Round = SumW'(2);

   // Two guard bits: enough for a four-term sum, and keeps unsigned values positive
   // so one signed compare serves both element encodings.
   function automatic logic signed [SumW-1:0] ext(input logic [DataWidth-1:0] v);
      if (Signed != 0) ext = {{2{v[DataWidth-1]}}, v};
      else             ext = {2'b00, v};
   endfunction

   logic signed [SumW-1:0] ea, eb, ec, ed, mab, mcd;
   logic [DataWidth-1:0]   vab, vcd, mx;
   logic [SumW-1:0]        sum;
   logic                   gt_ab, gt_cd;

   always_comb begin
      ea    = ext(a);
      eb    = ext(b);
      ec    = ext(c);
      ed    = ext(d);
      gt_ab = ea > eb;
      gt_cd = ec > ed;
      mab   = gt_ab ? ea : eb;
      mcd   = gt_cd ? ec : ed;
      vab   = gt_ab ? a : b;
      vcd   = gt_cd ? c : d;
      mx    = (mab > mcd) ? vab : vcd;
      sum   = ea + eb + ec + ed + Round;
      // Dropping the two low bits of the rounded sum is the arithmetic shift plus truncation.
      result = (mode == POOL_AVG) ? sum[SumW-1:2] : mx;
   end
endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2 pooling: buffers the even row of each pair, emits one half-width row per odd row.
module pool_stream
   import pool_pkg::*;
#(
   parameter int ByteWidth = 22,
   parameter int DataWidth = 8,
   parameter int Signed    = 0
) (
   input  logic        clk,
   input  logic        rst,
   pool_stream_if.slave bus,
   output pool_state_e state_dbg
);
   localparam int InW  = ByteWidth * DataWidth;
   localparam int OutW = (ByteWidth / 2) * DataWidth;

   pool_state_e     state;
   logic [InW-1:0]  line_buf;
   logic [OutW-1:0] reduced;
   logic [OutW-1:0] out_data_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic            err_q;
   logic            in_ready_c;
   logic            accept;

   for (genvar j = 0; j < ByteWidth / 2; j++) begin : g_win
      pool_reduce4 #(
         .DataWidth(DataWidth),
         .Signed   (Signed)
      ) u_reduce (
         .a     (line_buf[(2*j)*DataWidth +: DataWidth]),
         .b     (line_buf[(2*j+1)*DataWidth +: DataWidth]),
         .c     (bus.in_data[(2*j)*DataWidth +: DataWidth]),
         .d     (bus.in_data[(2*j+1)*DataWidth +: DataWidth]),
         .mode  (bus.mode),
         .result(reduced[j*DataWidth +: DataWidth])
      );
   end

   // The even row never touches the output register, so it is always accepted.
   always_comb begin
      in_ready_c = 1'b0;
      if (!rst) in_ready_c = (state == FIRST) || !out_valid_q || bus.out_ready;
   end

   assign accept = bus.in_valid && in_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FIRST;
         line_buf    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         if (accept) begin
            case (state)
               FIRST: begin
                  // A frame closing on an even row has no partner; drop it and flag it.
                  if (bus.in_last) begin
                     err_q <= 1'b1;
                  end else begin
                     line_buf <= bus.in_data;
                     state    <= SECOND;
                  end
               end
               SECOND: begin
                  out_data_q  <= reduced;
                  out_valid_q <= 1'b1;
                  out_last_q  <= bus.in_last;
                  state       <= FIRST;
               end
               default: state <= FIRST;
            endcase
         end
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_last      = out_last_q;
   assign bus.err_odd_frame = err_q;
   assign state_dbg         = state;
endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: an unsigned and a signed instance share one input stream.
module tb_pool_stream;
   import pool_pkg::*;

   localparam int BW   = 4;
   localparam int DW   = 8;
   localparam int IW   = BW * DW;
   localparam int OW   = (BW / 2) * DW;
   localparam int EXPW = 1 + 2 * OW;

   logic clk = 1'b0;
   logic rst;
   logic mode, in_valid, in_last, out_ready;
   logic [IW-1:0] in_data;
   pool_state_e state_u, state_s;

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt_u = 0;
   int err_cnt_s = 0;
   int exp_err   = 0;
   bit rand_ready = 1'b0;

   logic [EXPW-1:0] exp_q[$];

   pool_stream_if #(.ByteWidth(BW), .DataWidth(DW)) bus_u ();
   pool_stream_if #(.ByteWidth(BW), .DataWidth(DW)) bus_s ();

   assign bus_u.mode = mode;       assign bus_s.mode = mode;
   assign bus_u.in_valid = in_valid; assign bus_s.in_valid = in_valid;
   assign bus_u.in_data = in_data; assign bus_s.in_data = in_data;
   assign bus_u.in_last = in_last; assign bus_s.in_last = in_last;
   assign bus_u.out_ready = out_ready; assign bus_s.out_ready = out_ready;

   pool_stream #(.ByteWidth(BW), .DataWidth(DW), .Signed(0)) dut_u (
      .clk(clk), .rst(rst), .bus(bus_u.slave), .state_dbg(state_u));
   pool_stream #(.ByteWidth(BW), .DataWidth(DW), .Signed(1)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s.slave), .state_dbg(state_s));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each output element is the max or rounded mean of its 2x2 window.
   function automatic logic [OW-1:0] model(input logic [IW-1:0] r0, input logic [IW-1:0] r1,
                                           input logic m, input bit sgn);
      logic [OW-1:0] res;
      logic [DW-1:0] e[4];
      int v[4];
      int mx, s;
      logic [31:0] t;
      res = '0;
      for (int j = 0; j < BW / 2; j++) begin
         e[0] = r0[(2*j)*DW +: DW];
         e[1] = r0[(2*j+1)*DW +: DW];
         e[2] = r1[(2*j)*DW +: DW];
         e[3] = r1[(2*j+1)*DW +: DW];
         s = 2;
         for (int k = 0; k < 4; k++) begin
            v[k] = sgn ? int'($signed(e[k])) : int'(e[k]);
            s += v[k];
         end
         mx = v[0];
         for (int k = 1; k < 4; k++) if (v[k] > mx) mx = v[k];
         t = m ? (s >>> 2) : mx;
         res[j*DW +: DW] = t[DW-1:0];
      end
      return res;
   endfunction

   function automatic logic [EXPW-1:0] expect_pair(input logic [IW-1:0] r0, input logic [IW-1:0] r1,
                                                   input logic m, input logic last);
      return {last, model(r0, r1, m, 1'b0), model(r0, r1, m, 1'b1)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Offers one row and returns one step past the edge that accepted it.
   task automatic send_row(input logic [IW-1:0] d, input logic last, input logic m);
      int n;
      n = 0;
      in_data = d; in_last = last; mode = m; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus_u.in_ready) begin
            check("in_ready_match", 32'(bus_s.in_ready), 32'(bus_u.in_ready));
            break;
         end
         n++;
         if (n > 64) begin
            check("send_timeout", 32'd0, 32'd1);
            break;
         end
         tick();
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Scoreboard: a transfer happens on the next edge when valid and ready are seen here.
   always @(negedge clk) begin
      logic [EXPW-1:0] e;
      if (!rst) begin
         if (bus_u.err_odd_frame) err_cnt_u++;
         if (bus_s.err_odd_frame) err_cnt_s++;
         if (bus_u.out_valid || bus_s.out_valid)
            check("valid_match", 32'(bus_s.out_valid), 32'(bus_u.out_valid));
         if (bus_u.out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_data_unsigned", 32'(bus_u.out_data), 32'(e[2*OW-1:OW]));
               check("out_data_signed", 32'(bus_s.out_data), 32'(e[OW-1:0]));
               check("out_last", 32'(bus_u.out_last), 32'(e[EXPW-1]));
            end
         end
      end
   end

   typedef struct {
      logic [IW-1:0] row0;
      logic [IW-1:0] row1;
      logic          md;
      logic          last;
      logic [OW-1:0] exp_u;
      logic [OW-1:0] exp_s;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [IW-1:0] r0, r1, a0, a1, b0, b1;
      logic [OW-1:0] exp_a_u, exp_b_u;
      logic m, last, have0;

      vecs[0] = '{32'h0605F010, 32'h04070120, POOL_MAX, 1'b0, 16'h07F0, 16'h0720};
      vecs[1] = '{32'hFFFF0201, 32'hFFFF0202, POOL_AVG, 1'b1, 16'hFF02, 16'hFF02};
      vecs[2] = '{32'hFFFFFF80, 32'hFEFF007F, POOL_MAX, 1'b0, 16'hFFFF, 16'hFF7F};
      vecs[3] = '{32'h8080FFFF, 32'h8080FEFF, POOL_AVG, 1'b1, 16'h80FF, 16'h80FF};
      vecs[4] = '{32'h807F0100, 32'h7F7F0000, POOL_AVG, 1'b0, 16'h7F00, 16'h3F00};
      vecs[5] = '{32'h7F800000, 32'h00810000, POOL_MAX, 1'b1, 16'h8100, 16'h7F00};

      // Reset state
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus_u.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus_u.out_valid), 32'd0);
      check("rst_out_data", 32'(bus_u.out_data), 32'd0);
      check("rst_out_last", 32'(bus_s.out_last), 32'd0);
      check("rst_err", 32'(bus_u.err_odd_frame), 32'd0);
      check("rst_state", 32'(state_u), 32'(FIRST));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", 32'(bus_u.in_ready), 32'd1);
      @(posedge clk); #1;

      // Directed vectors
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_row(vecs[i].row0, 1'b0, ~vecs[i].md);
         check("state_second", 32'(state_s), 32'(SECOND));
         exp_q.push_back({vecs[i].last, vecs[i].exp_u, vecs[i].exp_s});
         send_row(vecs[i].row1, vecs[i].last, vecs[i].md);
         check("latency_out_valid", 32'(bus_u.out_valid), 32'd1);
      end
      tick();

      // Backpressure with a pooled row pending
      out_ready = 1'b0;
      a0 = 32'h11223344; a1 = 32'h55667788; b0 = 32'h99AABBCC; b1 = 32'hDDEEFF00;
      exp_a_u = model(a0, a1, POOL_MAX, 1'b0);
      exp_b_u = model(b0, b1, POOL_AVG, 1'b0);
      send_row(a0, 1'b0, POOL_AVG);
      exp_q.push_back(expect_pair(a0, a1, POOL_MAX, 1'b0));
      send_row(a1, 1'b0, POOL_MAX);
      send_row(b0, 1'b0, POOL_MAX);
      exp_q.push_back(expect_pair(b0, b1, POOL_AVG, 1'b1));
      in_data = b1; in_last = 1'b1; mode = POOL_AVG; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", 32'(bus_u.in_ready), 32'd0);
         check("bp_data_stable", 32'(bus_u.out_data), 32'(exp_a_u));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_high", 32'(bus_u.in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_new_valid", 32'(bus_u.out_valid), 32'd1);
      check("bp_new_data", 32'(bus_u.out_data), 32'(exp_b_u));
      tick();

      // Odd frame: third row closes the frame unpaired
      r0 = 32'h01020304; r1 = 32'hF0E0D0C0;
      send_row(r0, 1'b0, POOL_AVG);
      exp_q.push_back(expect_pair(r0, r1, POOL_MAX, 1'b0));
      send_row(r1, 1'b0, POOL_MAX);
      send_row(32'hAAAAAAAA, 1'b1, POOL_AVG);
      exp_err++;
      check("odd_err_pulse_u", 32'(bus_u.err_odd_frame), 32'd1);
      check("odd_err_pulse_s", 32'(bus_s.err_odd_frame), 32'd1);
      check("odd_state_first", 32'(state_u), 32'(FIRST));
      tick();
      check("odd_err_clear", 32'(bus_u.err_odd_frame), 32'd0);
      r0 = 32'h7F00807F; r1 = 32'h01FF0280;
      send_row(r0, 1'b0, POOL_MAX);
      exp_q.push_back(expect_pair(r0, r1, POOL_AVG, 1'b1));
      send_row(r1, 1'b1, POOL_AVG);
      tick();

      // Reset after the even row of a pair
      send_row(32'hFFFFFFFF, 1'b0, POOL_MAX);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_in_ready", 32'(bus_u.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_state", 32'(state_u), 32'(FIRST));
      check("rst_mid_valid", 32'(bus_u.out_valid), 32'd0);
      r0 = 32'h10203040; r1 = 32'h05060708;
      send_row(r0, 1'b0, POOL_MAX);
      exp_q.push_back(expect_pair(r0, r1, POOL_MAX, 1'b1));
      send_row(r1, 1'b1, POOL_MAX);
      tick();

      // Random stream with random downstream stalls
      rand_ready = 1'b1;
      have0 = 1'b0;
      r0 = '0;
      for (int i = 0; i < 200; i++) begin
         r1 = IW'($urandom);
         last = ($urandom_range(0, 3) == 0);
         m = 1'($urandom_range(0, 1));
         if (!have0) begin
            if (last) exp_err++;
            else begin r0 = r1; have0 = 1'b1; end
         end else begin
            exp_q.push_back(expect_pair(r0, r1, m, last));
            have0 = 1'b0;
         end
         send_row(r1, last, m);
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      repeat (2) tick();
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("err_count_u", 32'(err_cnt_u), 32'(exp_err));
      check("err_count_s", 32'(err_cnt_s), 32'(exp_err));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2x2 pooling engine for the CNN feature-map path. Accepts one full feature-map row per beat over a valid/ready handshake and buffers even rows internally. On each odd row it emits one pooled row of half width, in either max or rounded-average mode, signed or unsigned. It sits between the row-wise convolution output and the feature-map writeback, and replaces stateless two-line pooling that needed both rows presented at once.

## Interface
- ByteWidth, 22, elements per input row; must be even; output row has ByteWidth/2 elements
- DataWidth, 8, bits per element
- Signed, 0, 1 = elements are two's complement for compare/average; 0 = unsigned
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- mode  input  1  0 = max, 1 = average; sampled on acceptance of the second (odd) row
- in_valid  input  1  input row valid
- in_ready  output  1  input row accepted when in_valid && in_ready
- in_data  input  ByteWidth*DataWidth  row; element i at bits [i*DataWidth +: DataWidth]
- in_last  input  1  row is last of frame
- out_valid  output  1  pooled row valid
- out_ready  input  1  downstream accepts pooled row
- out_data  output  ByteWidth/2*DataWidth  pooled row; element j at [j*DataWidth +: DataWidth]
- out_last  output  1  pooled row closes frame
- err_odd_frame  output  1  one-cycle pulse: frame ended on an even row

## Operation
- States: FIRST (waiting for row 0 of a pair), SECOND (row 0 held in line buffer, waiting for row 1).
- FIRST: in_ready = 1. On accept, store in_data in line buffer and go to SECOND; if in_last=1, discard the row instead, stay in FIRST, pulse err_odd_frame next cycle.
- SECOND: in_ready = !out_valid || out_ready. On accept, compute out element j = reduce(buf[2j], buf[2j+1], in[2j], in[2j+1]), load output register, set out_valid=1, out_last=in_last, return to FIRST.
- Max: largest of 4, compared signed when Signed=1.
- Average: sum of 4 sign/zero-extended to DataWidth+2 bits, add 2, arithmetic shift right 2 (round half toward +inf), truncate to DataWidth. The result always fits.
- Output register: holds data/last stable while out_valid && !out_ready; out_valid clears on out_ready unless a new pooled row loads in the same cycle.
- Simultaneous out_ready and new second-row accept: new row replaces old with no bubble.
- Reset mid-pair: buffered row dropped, state FIRST, no output produced.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, err_odd_frame 0, state FIRST. in_ready is 0 while rst=1.
- Latency: out_valid rises the cycle after second-row acceptance.
- Throughput: one input row per cycle sustained with out_ready=1. One output per two input rows.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_*.
- err_odd_frame is registered and high exactly one cycle.

## Structure
- pool_pkg: mode constants (POOL_MAX=0, POOL_AVG=1), state enum {FIRST, SECOND}.
- Sub-module pool_reduce4 (parameters DataWidth, Signed; inputs a,b,c,d,mode; output result): combinational max/average of four elements. It is instantiated ByteWidth/2 times via generate.
- pool_stream holds the line buffer (ByteWidth*DataWidth flops), FSM and output register.

## Test plan
- Unsigned max, ByteWidth=4: row0 {0x10,0xF0,0x05,0x06}, row1 {0x20,0x01,0x07,0x04} (element 0 first) -> out {0xF0,0x07} one cycle after row1 accept.
- Average rounding: elements 1,2,2,2 -> sum 7, (7+2)>>2 = 2; elements 255 x4 -> 255.
- Signed=1 max: 0x80,0xFF,0x7F,0x00 -> 0x7F. Signed average of 0xFF,0xFF,0xFF,0xFE (sum -5) -> (-5+2)>>>2 = -1 (0xFF).
- Backpressure: out_ready=0 with a pooled row pending, third and fourth rows offered -> row 3 accepted, in_ready=0 in SECOND, out_data stable. Raise out_ready -> row 4 accepted the same cycle, new result next cycle, no loss.
- Odd frame: 3 rows with in_last on row 3 -> one pooled row with out_last=0, err_odd_frame pulses once, next row treated as FIRST.
- Reset after row 0 accepted: rst one cycle, then two rows -> exactly one output, computed only from the post-reset rows.
